// File: rtl/hex_bcd_pkg.sv
// Shared constants and elaboration helpers for the hex/BCD counter slice.
`timescale 1ns/1ps
package hex_bcd_pkg;

  // Default binary counter width and number of packed BCD digits.
  localparam int DEFAULT_HEX_W      = 4;
  localparam int DEFAULT_BCD_DIGITS = 2;

  // Every BCD digit is one nibble.
  localparam int BCD_DIGIT_W = 4;

  // Returns 10^n. Used only for constant elaboration checks.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

  // True when BCD_DIGITS decimal digits can hold every HEX_W-bit value.
  function automatic bit bcd_fits(input int hex_w, input int digits);
    longint unsigned max_bin;
    max_bin = (64'd1 << hex_w) - 64'd1;
    return (pow10(digits) - 64'd1) >= max_bin;
  endfunction

endpackage

// File: rtl/hex_bcd_counter_if.sv
// Output bundle of the counter: binary count and its packed BCD value.
`timescale 1ns/1ps
interface hex_bcd_counter_if
  import hex_bcd_pkg::*;
#(
  parameter int HEX_W      = DEFAULT_HEX_W,
  parameter int BCD_DIGITS = DEFAULT_BCD_DIGITS
);

  logic [HEX_W-1:0]                  hex;
  logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd;

  // The counter drives the bundle.
  modport master (output hex, output bcd);

  // Consumers of the count observe the bundle.
  modport slave (input hex, input bcd);

endinterface

// File: rtl/hex_bcd_counter_bin_to_bcd.sv
// Generic binary to packed-BCD converter using shift-and-add-3.
// Purely combinational; unused upper digits come out as zero naturally.
`timescale 1ns/1ps
module bin_to_bcd
  import hex_bcd_pkg::*;
#(
  parameter int HEX_W      = DEFAULT_HEX_W,
  parameter int BCD_DIGITS = DEFAULT_BCD_DIGITS
) (
  input  logic [HEX_W-1:0]                  bin,
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W  = BCD_DIGIT_W * BCD_DIGITS;
  localparam int WORK_W = BCD_W + HEX_W;

  // Refuse to build a converter whose BCD field cannot hold the largest input.
  if (!bcd_fits(HEX_W, BCD_DIGITS)) begin : g_width_check
    $error("bin_to_bcd: BCD_DIGITS too small for HEX_W");
  end

  logic [WORK_W-1:0] work;

  // Double-dabble: before each shift, bump any digit >= 5 by 3 so the shift carries into the next decade.
  always_comb begin
    work = '0;
    work[HEX_W-1:0] = bin;
    for (int i = 0; i < HEX_W; i++) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (work[HEX_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] > BCD_DIGIT_W'(4)) begin
          work[HEX_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] =
            work[HEX_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] + BCD_DIGIT_W'(3);
        end
      end
      work = work << 1;
    end
    bcd = work[HEX_W +: BCD_W];
  end

endmodule

// File: rtl/hex_bcd_counter.sv
// Free-running binary counter with a zero-latency packed-BCD view of the count.
// The count register is the only state; the BCD value is derived combinationally.
`timescale 1ns/1ps
module hex_bcd_counter
  import hex_bcd_pkg::*;
#(
  parameter int HEX_W      = DEFAULT_HEX_W,
  parameter int BCD_DIGITS = DEFAULT_BCD_DIGITS
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [HEX_W-1:0]                  hex,
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] bcd
);

  logic [HEX_W-1:0] count_d;
  logic [HEX_W-1:0] count_q;

  // Next count: always one more, wrapping naturally at 2^HEX_W.
  always_comb begin
    count_d = count_q + HEX_W'(1);
  end

  // Count register; reset clears it immediately and wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hex = count_q;

  bin_to_bcd #(
    .HEX_W      (HEX_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin_to_bcd (
    .bin (count_q),
    .bcd (bcd)
  );

endmodule

// File: tb/tb_hex_bcd_counter.sv
// Bench for hex_bcd_counter and bin_to_bcd against an arithmetic decimal model.
`timescale 1ns/1ps
module tb_hex_bcd_counter;

  localparam int HEX_W      = 4;
  localparam int BCD_DIGITS = 2;
  localparam int MODULUS    = 1 << HEX_W;

  logic clk;
  logic rst;

  hex_bcd_counter_if #(.HEX_W(HEX_W), .BCD_DIGITS(BCD_DIGITS)) cnt_if ();

  hex_bcd_counter #(.HEX_W(HEX_W), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .hex (cnt_if.hex),
    .bcd (cnt_if.bcd)
  );

  logic [3:0] conv_bin;
  logic [7:0] conv_bcd;
  bin_to_bcd #(.HEX_W(4), .BCD_DIGITS(2)) u_conv (
    .bin (conv_bin),
    .bcd (conv_bcd)
  );

  logic [7:0]  wide_bin;
  logic [11:0] wide_bcd;
  bin_to_bcd #(.HEX_W(8), .BCD_DIGITS(3)) u_conv_wide (
    .bin (wide_bin),
    .bcd (wide_bcd)
  );

  int vectors;
  int miscompares;
  int model_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal digits of v packed as BCD, computed with plain arithmetic.
  function automatic logic [11:0] bcd_of(input int v);
    logic [11:0] b;
    int r;
    b = '0;
    r = v;
    for (int d = 0; d < 3; d++) begin
      b[d*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  // One rising edge, advance the model, sample shortly after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_count = (model_count + 1) % MODULUS;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_count = 0;
    #2;
    vectors++;
    if (cnt_if.hex !== 4'd0 || cnt_if.bcd !== 8'h00) begin
      $display("[TB] FAIL reset_async hex=%0h bcd=%0h expected hex=0 bcd=00", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (cnt_if.hex !== 4'd0 || cnt_if.bcd !== 8'h00) begin
      $display("[TB] FAIL reset_hold hex=%0h bcd=%0h expected hex=0 bcd=00", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_digit();
    logic [7:0] exp_bcd;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_bcd = bcd_of(model_count)[7:0];
      vectors++;
      if (cnt_if.hex !== 4'(model_count) || cnt_if.bcd !== exp_bcd || cnt_if.bcd[7:4] !== 4'd0) begin
        $display("[TB] FAIL single_digit edge=%0d hex=%0d bcd=%0h expected hex=%0d bcd=%0h",
                 e, cnt_if.hex, cnt_if.bcd, model_count, exp_bcd);
        miscompares++;
      end
    end
  endtask

  task automatic test_decimal_carry();
    logic [7:0] exp_bcd;
    for (int e = 10; e <= 15; e++) begin
      step();
      exp_bcd = bcd_of(model_count)[7:0];
      vectors++;
      if (cnt_if.hex !== 4'(model_count) || cnt_if.bcd !== exp_bcd) begin
        $display("[TB] FAIL decimal_carry edge=%0d hex=%0d bcd=%0h expected hex=%0d bcd=%0h",
                 e, cnt_if.hex, cnt_if.bcd, model_count, exp_bcd);
        miscompares++;
      end
    end
    vectors++;
    if (cnt_if.hex !== 4'd15 || cnt_if.bcd !== 8'h15) begin
      $display("[TB] FAIL top_of_range hex=%0d bcd=%0h expected hex=15 bcd=15", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_bcd;
    step();
    vectors++;
    if (cnt_if.hex !== 4'd0 || cnt_if.bcd !== 8'h00) begin
      $display("[TB] FAIL wrap hex=%0d bcd=%0h expected hex=0 bcd=00", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    for (int e = 0; e < 2*MODULUS; e++) begin
      step();
      exp_bcd = bcd_of(model_count)[7:0];
      vectors++;
      if (cnt_if.hex !== 4'(model_count) || cnt_if.bcd !== exp_bcd) begin
        $display("[TB] FAIL wrap_repeat step=%0d hex=%0d bcd=%0h expected hex=%0d bcd=%0h",
                 e, cnt_if.hex, cnt_if.bcd, model_count, exp_bcd);
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    // Run to 7, then reset between edges.
    budget = 0;
    while (cnt_if.hex !== 4'd7 && budget < 40) begin
      step();
      budget++;
    end
    vectors++;
    if (cnt_if.hex !== 4'd7) begin
      $display("[TB] FAIL reach_seven timeout hex=%0d expected 7", cnt_if.hex);
      miscompares++;
    end
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    model_count = 0;
    #1;
    vectors++;
    if (cnt_if.hex !== 4'd0 || cnt_if.bcd !== 8'h00) begin
      $display("[TB] FAIL async_reset hex=%0d bcd=%0h expected hex=0 bcd=00", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    step();
    vectors++;
    if (cnt_if.hex !== 4'd0) begin
      $display("[TB] FAIL reset_over_edge hex=%0d expected 0", cnt_if.hex);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (cnt_if.hex !== 4'd1 || cnt_if.bcd !== 8'h01) begin
      $display("[TB] FAIL first_after_reset hex=%0d bcd=%0h expected hex=1 bcd=01", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    // Run to 15 and hold reset across the wrap edge.
    budget = 0;
    while (cnt_if.hex !== 4'd15 && budget < 40) begin
      step();
      budget++;
    end
    vectors++;
    if (cnt_if.hex !== 4'd15) begin
      $display("[TB] FAIL reach_fifteen timeout hex=%0d expected 15", cnt_if.hex);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    model_count = 0;
    step();
    vectors++;
    if (cnt_if.hex !== 4'd0 || cnt_if.bcd !== 8'h00) begin
      $display("[TB] FAIL reset_at_wrap hex=%0d bcd=%0h expected hex=0 bcd=00", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (cnt_if.hex !== 4'd1 || cnt_if.bcd !== 8'h01) begin
      $display("[TB] FAIL after_wrap_reset hex=%0d bcd=%0h expected hex=1 bcd=01", cnt_if.hex, cnt_if.bcd);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_bcd;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b1;
        model_count = 0;
        #1;
        rst = 1'b0;
      end else begin
        step();
      end
      exp_bcd = bcd_of(model_count)[7:0];
      vectors++;
      if (cnt_if.hex !== 4'(model_count) || cnt_if.bcd !== exp_bcd) begin
        $display("[TB] FAIL random iter=%0d hex=%0d bcd=%0h expected hex=%0d bcd=%0h",
                 n, cnt_if.hex, cnt_if.bcd, model_count, exp_bcd);
        miscompares++;
      end
    end
  endtask

  task automatic test_converter();
    int tens;
    int units;
    int v;
    int start;
    start = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      v = (start + i) % 16;
      conv_bin = 4'(v);
      #1;
      tens  = int'(conv_bcd[7:4]);
      units = int'(conv_bcd[3:0]);
      vectors++;
      if (tens * 10 + units != v || tens > 9 || units > 9 || conv_bcd !== bcd_of(v)[7:0]) begin
        $display("[TB] FAIL converter in=%0d bcd=%0h expected bcd=%0h", v, conv_bcd, bcd_of(v)[7:0]);
        miscompares++;
      end
    end
    for (int i = 0; i < 24; i++) begin
      v = (i < 4) ? (i * 85) : int'($urandom_range(0, 255));
      wide_bin = 8'(v);
      #1;
      vectors++;
      if (wide_bcd !== bcd_of(v)) begin
        $display("[TB] FAIL converter_wide in=%0d bcd=%0h expected bcd=%0h", v, wide_bcd, bcd_of(v));
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_count = 0;
    conv_bin    = '0;
    wide_bin    = '0;
    rst         = 1'b1;
    test_reset();
    test_single_digit();
    test_decimal_carry();
    test_wrap();
    test_async_reset();
    test_random();
    test_converter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
